// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//   Operand / result handshake bundle for seq_divider.
//   master : operand producer and result consumer
//            drives in_valid, dividend, divisor, is_signed, out_ready
//   slave  : the divider
//            drives in_ready, out_valid, quotient, remainder, div_zero
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative radix-2 non-restoring integer divider, one quotient bit per
//   cycle, one division in flight. Signed mode truncates toward zero and the
//   remainder follows the dividend's sign.
//
//   Ports
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     bus   : seq_divider_if.slave
//               in_valid/in_ready + dividend, divisor, is_signed  (operands)
//               out_valid/out_ready + quotient, remainder, div_zero (result)
//
//   Latency (accept edge to out_valid): WIDTH+2 normally, 1 for divide by zero
//   and for signed most-negative / -1.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;          // signed partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] d_q, d_d;          // |divisor|
    logic             sgn_q, sgn_d;
    logic             aneg_q, aneg_d;
    logic             bneg_q, bneg_d;
    logic             dz_q, dz_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;

    logic             in_ready;
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             is_div0, is_ovf;
    logic [WIDTH:0]   shifted, step;
    logic [WIDTH-1:0] rfix, fix_q, fix_r;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = bus.in_valid && in_ready;

    // Operand preprocessing at accept time
    assign a_neg   = bus.is_signed && bus.dividend[WIDTH-1];
    assign b_neg   = bus.is_signed && bus.divisor[WIDTH-1];
    assign a_abs   = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_abs   = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign is_div0 = (bus.divisor == '0);
    assign is_ovf  = bus.is_signed
                  && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (bus.divisor == '1);

    // One non-restoring step. The shifted value may wrap in WIDTH+1 bits, but
    // the add/sub result always lands back in [-D, D), so modular arithmetic
    // gives the right partial remainder.
    assign shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign step    = p_q[WIDTH] ? (shifted + {1'b0, d_q}) : (shifted - {1'b0, d_q});

    // Final correction: a negative remainder gets the divisor added back; the
    // corrected value is in [0, D) so WIDTH bits suffice.
    assign rfix  = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
    assign fix_q = (sgn_q && (aneg_q ^ bneg_q)) ? (~q_q + 1'b1) : q_q;
    assign fix_r = (sgn_q && aneg_q) ? (~rfix + 1'b1) : rfix;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        sgn_d       = sgn_q;
        aneg_d      = aneg_q;
        bneg_d      = bneg_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sgn_d  = bus.is_signed;
                    aneg_d = a_neg;
                    bneg_d = b_neg;
                    d_d    = b_abs;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    // Special results are parked in q/p so DONE publishes
                    // every result the same way.
                    if (is_div0) begin
                        q_d     = '1;
                        p_d     = {1'b0, bus.dividend};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (is_ovf) begin
                        q_d     = bus.dividend;
                        p_d     = '0;
                        state_d = DONE;
                    end else begin
                        q_d     = a_abs;
                        p_d     = '0;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                p_d   = step;
                q_d   = {q_q[WIDTH-2:0], ~step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_d     = fix_q;
                p_d     = {1'b0, fix_r};
                state_d = DONE;
            end
            DONE: begin
                // First DONE cycle loads the output registers; they then hold
                // until the consumer takes them.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    quot_d      = q_q;
                    rem_d       = p_q[WIDTH-1:0];
                    div_zero_d  = dz_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            sgn_q       <= 1'b0;
            aneg_q      <= 1'b0;
            bneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            sgn_q       <= sgn_d;
            aneg_q      <= aneg_d;
            bneg_q      <= bneg_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Scoreboarded bench for seq_divider (WIDTH = 32). The driver pushes the
//   expected result from an arithmetic reference model at accept time; a
//   negedge monitor pops and compares whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               acc;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division in 64-bit arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
        exp_t   e;
        longint sa, sb;
        e.acc = 0;
        e.dz  = 1'b0;
        e.lat = WIDTH + 2;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            e.q = WIDTH'(sa / sb);
            e.r = WIDTH'(sa % sb);
            if (sa == -(64'sd1 <<< (WIDTH - 1)) && sb == -1) e.lat = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        int   n;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'd1, 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        e     = model(a, b, s);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        // Garbage on the operand lines must not disturb the division in flight.
        bus.in_valid  = 1'b0;
        bus.dividend  = $urandom();
        bus.divisor   = $urandom();
        bus.is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'd1, 64'd0);
    endtask

    // Monitor: compare on first presentation, then require stability while held.
    logic             have = 1'b0;
    logic [WIDTH-1:0] h_q, h_r;
    logic             h_dz;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have = 1'b0;
        end else if (bus.out_valid) begin
            if (!have) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", 64'(bus.quotient), 64'(e.q));
                    chk("remainder", 64'(bus.remainder), 64'(e.r));
                    chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
                h_q  = bus.quotient;
                h_r  = bus.remainder;
                h_dz = bus.div_zero;
                have = 1'b1;
            end else begin
                chk("hold_quotient", 64'(bus.quotient), 64'(h_q));
                chk("hold_remainder", 64'(bus.remainder), 64'(h_r));
                chk("hold_div_zero", 64'(bus.div_zero), 64'(h_dz));
                chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            end
        end else begin
            have = 1'b0;
        end
    end

    initial begin
        int kind;
        logic [WIDTH-1:0] a, b;
        logic s;
        int n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_quotient", 64'(bus.quotient), 64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Directed cases
        issue(32'd100, 32'd7, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);          // -7 / 2
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);          // 7 / -2
        issue(32'h1234_5678, 32'd0, 1'b0);          // divide by zero
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  // signed overflow
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  // same bits, unsigned: normal path
        issue(32'hFFFF_FFF9, 32'd0, 1'b1);          // signed divide by zero

        // Backpressure: result held for 10 cycles, then released
        wait_valid();
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(32'd100, 32'd7, 1'b0);
        wait_valid();
        repeat (10) @(negedge clk);
        chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_valid_fall", 64'(bus.out_valid), 64'd0);
        chk("bp_in_ready_rise", 64'(bus.in_ready), 64'd1);
        issue(32'd12345, 32'd67, 1'b0);              // back-to-back accept

        // Reset during ITER, 15 cycles after accept
        wait_valid();
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'd13, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        issue(32'd9, 32'd3, 1'b0);

        // Random pairs with corner-case biasing
        for (int i = 0; i < 1000; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom();
            b    = $urandom();
            s    = 1'($urandom_range(0, 1));
            case (kind)
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                2: b = WIDTH'($urandom_range(1, 15)) ^ ({WIDTH{b[31]}} & {WIDTH{s}});
                3: a = WIDTH'($urandom_range(0, 100));
                4: b = a;
                default: ;
            endcase
            issue(a, b, s);
        end

        // Drain
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
